// File: rtl/adam_obi_ram_dift_if.sv
// rtl/adam_obi_ram_dift_if.sv - clock/reset sequencing bundle shared by ADAM blocks
interface ADAM_SEQ;
    logic clk;
    logic rst;

    modport Master (output clk, output rst);
    modport Slave  (input  clk, input  rst);
endinterface

// File: rtl/adam_obi_ram_dift.sv
// rtl/adam_obi_ram_dift.sv - OBI responder SRAM with per-byte DIFT tags
// Fixed-latency response pipeline with a RUN/DRAIN/PAUSED quiesce FSM.
module adam_obi_ram_dift #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned           SIZE       = 65536,
    parameter int unsigned           LATENCY    = 1
) (
    ADAM_SEQ.Slave                  seq,
    input  logic                    pause_req,
    output logic                    pause_ack,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    we_tag_i,
    input  logic                    wdata_tag_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [DATA_WIDTH/8-1:0] rdata_tag_o,
    output logic                    err_o,
    output logic                    dropped_o
);
    localparam int unsigned STRB  = DATA_WIDTH / 8;
    localparam int unsigned BW    = $clog2(STRB);
    localparam int unsigned AW    = $clog2(SIZE);
    localparam int unsigned WORDS = SIZE / STRB;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [STRB-1:0]       tag_q [WORDS];

    logic                  pv_q   [LATENCY];
    logic                  perr_q [LATENCY];
    logic [DATA_WIDTH-1:0] pdata_q[LATENCY];
    logic [STRB-1:0]       ptag_q [LATENCY];

    logic [1:0] state_q, state_d;
    logic       dropped_q;

    logic [ADDR_WIDTH-1:0] off;
    logic [AW-BW-1:0]      idx;
    logic                  in_range, accept, wr_en, rd_en, pipe_busy;
    logic                  unused_off;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    assign off        = addr_i - BASE_ADDR;
    assign in_range   = off < ADDR_WIDTH'(SIZE);
    assign idx        = off[AW-1:BW];
    assign unused_off = ^{off[ADDR_WIDTH-1:AW], off[BW-1:0]};

    assign gnt_o  = req_i && (state_q == RUN) && !pause_req;
    assign accept = req_i && gnt_o;
    assign wr_en  = accept && we_i && in_range;
    assign rd_en  = accept && !we_i && in_range;

    always_ff @(posedge seq.clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                    if (we_tag_i) tag_q[idx][b] <= wdata_tag_i;
                end
            end
        end
    end

    always_ff @(posedge seq.clk) begin
        if (seq.rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pv_q[i]    <= 1'b0;
                perr_q[i]  <= 1'b0;
                pdata_q[i] <= '0;
                ptag_q[i]  <= '0;
            end
        end else begin
            pv_q[0]    <= accept;
            perr_q[0]  <= accept && !in_range;
            pdata_q[0] <= rd_en ? mem_q[idx] : '0;
            ptag_q[0]  <= rd_en ? tag_q[idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i]    <= pv_q[i-1];
                perr_q[i]  <= perr_q[i-1];
                pdata_q[i] <= pdata_q[i-1];
                ptag_q[i]  <= ptag_q[i-1];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) pipe_busy = pipe_busy | pv_q[i];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (pause_req) state_d = DRAIN;
            DRAIN:   if (!pause_req) state_d = RUN;
                     else if (!pipe_busy) state_d = PAUSED;
            PAUSED:  if (!pause_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge seq.clk) begin
        if (seq.rst) begin
            state_q   <= RUN;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dropped_q <= dropped_q | (req_i && (state_q != RUN));
        end
    end

    assign pause_ack   = (state_q == PAUSED);
    assign dropped_o   = dropped_q;
    assign rvalid_o    = pv_q[LATENCY-1];
    assign err_o       = perr_q[LATENCY-1];
    assign rdata_o     = pdata_q[LATENCY-1];
    assign rdata_tag_o = ptag_q[LATENCY-1];
endmodule

// File: tb/tb_adam_obi_ram_dift.sv
// tb/tb_adam_obi_ram_dift.sv - directed bench for adam_obi_ram_dift at LATENCY 1..3
module tb_adam_obi_ram_dift;
    ADAM_SEQ seq_if ();

    logic        pause_req, req, we, we_tag, wtag;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    logic        gnt[1:3], pack[1:3], rvalid[1:3], err[1:3], dropped[1:3];
    logic [31:0] rdata[1:3];
    logic [3:0]  rtag[1:3];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        adam_obi_ram_dift #(.LATENCY(g)) u_dut (
            .seq         (seq_if.Slave),
            .pause_req   (pause_req),
            .pause_ack   (pack[g]),
            .req_i       (req),
            .gnt_o       (gnt[g]),
            .addr_i      (addr),
            .we_i        (we),
            .be_i        (be),
            .wdata_i     (wdata),
            .we_tag_i    (we_tag),
            .wdata_tag_i (wtag),
            .rvalid_o    (rvalid[g]),
            .rdata_o     (rdata[g]),
            .rdata_tag_o (rtag[g]),
            .err_o       (err[g]),
            .dropped_o   (dropped[g])
        );
    end

    initial seq_if.clk = 1'b0;
    always #5 seq_if.clk = ~seq_if.clk;

    task automatic step();
        @(posedge seq_if.clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic wt, input logic t);
        req = r; we = w; addr = a; be = b; wdata = d; we_tag = wt; wtag = t;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        seq_if.rst = 1'b1; pause_req = 1'b0;
        idle();
        step(); step(); step();
        seq_if.rst = 1'b0;
        for (int g = 1; g <= 3; g++) begin
            n_vec++; if (rvalid[g] !== 1'b0) begin n_err++; $display("FAIL reset_rvalid L%0d got %b want 0", g, rvalid[g]); end
            n_vec++; if (rdata[g] !== 32'h0) begin n_err++; $display("FAIL reset_rdata L%0d got %h want 0", g, rdata[g]); end
            n_vec++; if (rtag[g] !== 4'h0) begin n_err++; $display("FAIL reset_rtag L%0d got %h want 0", g, rtag[g]); end
            n_vec++; if (err[g] !== 1'b0) begin n_err++; $display("FAIL reset_err L%0d got %b want 0", g, err[g]); end
            n_vec++; if (dropped[g] !== 1'b0) begin n_err++; $display("FAIL reset_dropped L%0d got %b want 0", g, dropped[g]); end
            n_vec++; if (pack[g] !== 1'b0) begin n_err++; $display("FAIL reset_pause_ack L%0d got %b want 0", g, pack[g]); end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'h0200_0010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
        n_vec++; if (gnt[1] !== 1'b1) begin n_err++; $display("FAIL wr_gnt got %b want 1", gnt[1]); end
        step();
        drive(1'b1, 1'b0, 32'h0200_0010, 4'h0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (gnt[1] !== 1'b1) begin n_err++; $display("FAIL rd_gnt got %b want 1", gnt[1]); end
        n_vec++; if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL wr_rvalid got %b want 1", rvalid[1]); end
        n_vec++; if (rdata[1] !== 32'h0) begin n_err++; $display("FAIL wr_rdata got %h want 0", rdata[1]); end
        n_vec++; if (err[1] !== 1'b0) begin n_err++; $display("FAIL wr_err got %b want 0", err[1]); end
        step();
        idle();
        n_vec++; if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL rd_rvalid got %b want 1", rvalid[1]); end
        n_vec++; if (rdata[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata got %h want deadbeef", rdata[1]); end
        n_vec++; if (rtag[1] !== 4'hF) begin n_err++; $display("FAIL rd_rtag got %h want f", rtag[1]); end
        step();
        n_vec++; if (rvalid[1] !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_drop got %b want 0", rvalid[1]); end
        n_vec++; if (rdata[1] !== 32'h0) begin n_err++; $display("FAIL rd_rdata_idle got %h want 0", rdata[1]); end
    endtask

    task automatic test_partial();
        drive(1'b1, 1'b1, 32'h0200_0020, 4'hF, 32'h11223344, 1'b1, 1'b1); step();
        drive(1'b1, 1'b1, 32'h0200_0020, 4'h2, 32'h0000AA00, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0200_0022, 4'h0, 32'h0, 1'b0, 1'b0); step();
        idle();
        n_vec++; if (rdata[1] !== 32'h1122AA44) begin n_err++; $display("FAIL part_be2_data got %h want 1122aa44", rdata[1]); end
        n_vec++; if (rtag[1] !== 4'hF) begin n_err++; $display("FAIL part_be2_tag got %h want f", rtag[1]); end
        drive(1'b1, 1'b1, 32'h0200_0020, 4'h1, 32'hFFFFFF55, 1'b1, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0200_0020, 4'hF, 32'h0, 1'b0, 1'b0); step();
        idle();
        n_vec++; if (rdata[1] !== 32'h1122AA55) begin n_err++; $display("FAIL part_be1_data got %h want 1122aa55", rdata[1]); end
        n_vec++; if (rtag[1] !== 4'hE) begin n_err++; $display("FAIL part_be1_tag got %h want e", rtag[1]); end
        drive(1'b1, 1'b1, 32'h0200_0020, 4'h0, 32'h0, 1'b1, 1'b1); step();
        idle();
        n_vec++; if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL be0_rvalid got %b want 1", rvalid[1]); end
        drive(1'b1, 1'b0, 32'h0200_0020, 4'h0, 32'h0, 1'b0, 1'b0); step();
        idle();
        n_vec++; if (rdata[1] !== 32'h1122AA55) begin n_err++; $display("FAIL be0_data got %h want 1122aa55", rdata[1]); end
        n_vec++; if (rtag[1] !== 4'hE) begin n_err++; $display("FAIL be0_tag got %h want e", rtag[1]); end
        step();
    endtask

    task automatic test_back_to_back();
        logic        vw[5];
        logic [31:0] va[5], vd[5], ed[5];
        logic [3:0]  et[5];
        logic        exp_v;
        vw[0] = 1'b1; va[0] = 32'h0200_0030; vd[0] = 32'h000000A1; ed[0] = 32'h0;        et[0] = 4'h0;
        vw[1] = 1'b1; va[1] = 32'h0200_0034; vd[1] = 32'h000000B2; ed[1] = 32'h0;        et[1] = 4'h0;
        vw[2] = 1'b0; va[2] = 32'h0200_0030; vd[2] = 32'h0;        ed[2] = 32'h000000A1; et[2] = 4'hF;
        vw[3] = 1'b0; va[3] = 32'h0200_0034; vd[3] = 32'h0;        ed[3] = 32'h000000B2; et[3] = 4'h0;
        vw[4] = 1'b0; va[4] = 32'h0200_0010; vd[4] = 32'h0;        ed[4] = 32'hDEADBEEF; et[4] = 4'hF;
        idle(); step(); step(); step();
        for (int c = 0; c < 10; c++) begin
            if (c < 5) drive(1'b1, vw[c], va[c], 4'hF, vd[c], 1'b1, (c == 0));
            else idle();
            if (c < 5) begin
                n_vec++; if (gnt[3] !== 1'b1) begin n_err++; $display("FAIL b2b_gnt c%0d got %b want 1", c, gnt[3]); end
            end
            exp_v = (c >= 3) && (c < 8);
            n_vec++; if (rvalid[3] !== exp_v) begin n_err++; $display("FAIL b2b_rvalid c%0d got %b want %b", c, rvalid[3], exp_v); end
            if (exp_v) begin
                n_vec++; if (rdata[3] !== ed[c-3]) begin n_err++; $display("FAIL b2b_rdata c%0d got %h want %h", c, rdata[3], ed[c-3]); end
                n_vec++; if (rtag[3] !== et[c-3]) begin n_err++; $display("FAIL b2b_rtag c%0d got %h want %h", c, rtag[3], et[c-3]); end
                n_vec++; if (err[3] !== 1'b0) begin n_err++; $display("FAIL b2b_err c%0d got %b want 0", c, err[3]); end
            end
            step();
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b1, 32'h0200_0000, 4'hF, 32'h01020304, 1'b1, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0201_0000, 4'hF, 32'h0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 32'h0100_0000, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1);
        n_vec++; if (err[1] !== 1'b1) begin n_err++; $display("FAIL oor_rd_err got %b want 1", err[1]); end
        n_vec++; if (rdata[1] !== 32'h0) begin n_err++; $display("FAIL oor_rd_data got %h want 0", rdata[1]); end
        n_vec++; if (rtag[1] !== 4'h0) begin n_err++; $display("FAIL oor_rd_tag got %h want 0", rtag[1]); end
        step();
        drive(1'b1, 1'b1, 32'h0200_FFFC, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1);
        n_vec++; if ((rvalid[1] & err[1]) !== 1'b1) begin n_err++; $display("FAIL oor_wr_err got %b want 1", rvalid[1] & err[1]); end
        n_vec++; if (rdata[1] !== 32'h0) begin n_err++; $display("FAIL oor_wr_data got %h want 0", rdata[1]); end
        step();
        drive(1'b1, 1'b0, 32'h0200_0000, 4'hF, 32'h0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0200_FFFC, 4'hF, 32'h0, 1'b0, 1'b0);
        n_vec++; if (rdata[1] !== 32'h01020304) begin n_err++; $display("FAIL oor_no_alias_data got %h want 01020304", rdata[1]); end
        n_vec++; if (rtag[1] !== 4'h0) begin n_err++; $display("FAIL oor_no_alias_tag got %h want 0", rtag[1]); end
        n_vec++; if (err[1] !== 1'b0) begin n_err++; $display("FAIL oor_inrange_err got %b want 0", err[1]); end
        step();
        idle();
        n_vec++; if (rdata[1] !== 32'hCAFEF00D) begin n_err++; $display("FAIL last_word_data got %h want cafef00d", rdata[1]); end
        n_vec++; if (err[1] !== 1'b0) begin n_err++; $display("FAIL last_word_err got %b want 0", err[1]); end
        step();
    endtask

    task automatic test_pause();
        drive(1'b1, 1'b0, 32'h0200_0010, 4'hF, 32'h0, 1'b0, 1'b0);
        n_vec++; if (gnt[1] !== 1'b1) begin n_err++; $display("FAIL pause_pre_gnt got %b want 1", gnt[1]); end
        step();
        pause_req = 1'b1; #1;
        n_vec++; if (gnt[1] !== 1'b0) begin n_err++; $display("FAIL pause_gnt_block got %b want 0", gnt[1]); end
        n_vec++; if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL pause_inflight_rvalid got %b want 1", rvalid[1]); end
        n_vec++; if (rdata[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pause_inflight_data got %h want deadbeef", rdata[1]); end
        step();
        n_vec++; if (pack[1] !== 1'b0) begin n_err++; $display("FAIL drain_ack got %b want 0", pack[1]); end
        n_vec++; if (dropped[1] !== 1'b0) begin n_err++; $display("FAIL drain_dropped got %b want 0", dropped[1]); end
        n_vec++; if (rvalid[1] !== 1'b0) begin n_err++; $display("FAIL drain_rvalid got %b want 0", rvalid[1]); end
        step();
        n_vec++; if (pack[1] !== 1'b1) begin n_err++; $display("FAIL paused_ack got %b want 1", pack[1]); end
        n_vec++; if (dropped[1] !== 1'b1) begin n_err++; $display("FAIL paused_dropped got %b want 1", dropped[1]); end
        pause_req = 1'b0; #1;
        n_vec++; if (gnt[1] !== 1'b0) begin n_err++; $display("FAIL release_gnt_same got %b want 0", gnt[1]); end
        step();
        n_vec++; if (pack[1] !== 1'b0) begin n_err++; $display("FAIL release_ack got %b want 0", pack[1]); end
        n_vec++; if (gnt[1] !== 1'b1) begin n_err++; $display("FAIL release_gnt got %b want 1", gnt[1]); end
        step();
        idle();
        n_vec++; if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL release_rvalid got %b want 1", rvalid[1]); end
        n_vec++; if (dropped[1] !== 1'b1) begin n_err++; $display("FAIL dropped_sticky got %b want 1", dropped[1]); end
        step();
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b0, 32'h0200_0010, 4'hF, 32'h0, 1'b0, 1'b0);
        n_vec++; if (gnt[2] !== 1'b1) begin n_err++; $display("FAIL mrst_gnt got %b want 1", gnt[2]); end
        step();
        idle();
        seq_if.rst = 1'b1;
        step();
        seq_if.rst = 1'b0;
        n_vec++; if (rvalid[2] !== 1'b0) begin n_err++; $display("FAIL mrst_rvalid got %b want 0", rvalid[2]); end
        n_vec++; if (rdata[2] !== 32'h0) begin n_err++; $display("FAIL mrst_rdata got %h want 0", rdata[2]); end
        n_vec++; if (rtag[2] !== 4'h0) begin n_err++; $display("FAIL mrst_rtag got %h want 0", rtag[2]); end
        n_vec++; if (dropped[2] !== 1'b0) begin n_err++; $display("FAIL mrst_dropped got %b want 0", dropped[2]); end
        n_vec++; if (pack[2] !== 1'b0) begin n_err++; $display("FAIL mrst_ack got %b want 0", pack[2]); end
        step();
        n_vec++; if (rvalid[2] !== 1'b0) begin n_err++; $display("FAIL mrst_rvalid_late got %b want 0", rvalid[2]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_back_to_back();
        test_out_of_range();
        test_pause();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
